// File: rtl/ldpc_enc_pkg.sv
// ==== ldpc_enc_pkg : MODCOD width, Kldpc lookup and feeder FSM states ====
// ==== Rev 1.0 ====
`default_nettype none

package ldpc_enc_pkg;

   localparam int MODCOD_W = 5;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DROP     = 3'd1,
      WAIT_RDY = 3'd2,
      SOF      = 3'd3,
      DATA     = 3'd4
   } feed_state_t;

   // Kldpc of the normal-frame code selected by a DVB-S2 MODCOD; 0 marks an invalid MODCOD
   function automatic logic [15:0] kldpc_of(input logic [MODCOD_W-1:0] modcod);
      logic [15:0] k;
      case (modcod)
         5'd1:                      k = 16'd16200;
         5'd2:                      k = 16'd21600;
         5'd3:                      k = 16'd25920;
         5'd4:                      k = 16'd32400;
         5'd5,  5'd12:              k = 16'd38880;
         5'd6,  5'd13, 5'd18:       k = 16'd43200;
         5'd7,  5'd14, 5'd19, 5'd24: k = 16'd48600;
         5'd8,  5'd20, 5'd25:       k = 16'd51840;
         5'd9,  5'd15, 5'd21, 5'd26: k = 16'd54000;
         5'd10, 5'd16, 5'd22, 5'd27: k = 16'd57600;
         5'd11, 5'd17, 5'd23, 5'd28: k = 16'd58320;
         default:                   k = 16'd0;
      endcase
      return k;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ldpc_feed_fifo.sv
// ==== ldpc_feed_fifo : single-clock first-word-fall-through FIFO with registered flags ====
// ==== Rev 1.0 ====
`default_nettype none

module ldpc_feed_fifo #(
   parameter int W     = 14,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO is legal when the head leaves on the same edge
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + 1'b1;
      else if (do_pop && !do_push)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

`default_nettype wire

// File: rtl/ldpc_enc_frame_feeder.sv
// ==== ldpc_enc_frame_feeder : buffers BCH words and feeds ldpc_enc_64800 exact-length frames ====
// ==== Rev 1.0 -- LDPC_FEED_ERR_CNT_EN adds saturating error counters ====
`default_nettype none

module ldpc_enc_frame_feeder
   import ldpc_enc_pkg::*;
#(
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                srst,
   input  logic [DW-1:0]       s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                s_sof,
   input  logic [MODCOD_W-1:0] s_modcod,
   input  logic                enc_rdy,
   output logic                enc_sof,
   output logic [MODCOD_W-1:0] enc_modcod,
   output logic [DW-1:0]       enc_din,
   output logic                enc_din_valid,
   output logic                err_short,
   output logic                err_long,
   output logic                err_modcod
`ifdef LDPC_FEED_ERR_CNT_EN
   ,
   output logic [15:0]         cnt_short,
   output logic [15:0]         cnt_long,
   output logic [15:0]         cnt_modcod
`endif
);

   localparam int FW    = DW + 1 + MODCOD_W;
   localparam int SHIFT = $clog2(DW);

   logic [FW-1:0]       head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;
   logic                head_sof;
   logic [MODCOD_W-1:0] head_mc;
   logic [DW-1:0]       head_data;
   logic [15:0]         head_k;
   logic                head_mc_ok;

   feed_state_t         state;
   logic [15:0]         count;
   logic [MODCOD_W-1:0] mc_l;
   logic                first;
   logic                pad;

   assign s_ready    = !fifo_full;
   assign head_sof   = head[FW-1];
   assign head_mc    = head[DW +: MODCOD_W];
   assign head_data  = head[DW-1:0];
   assign head_k     = kldpc_of(head_mc);
   assign head_mc_ok = (head_k != 16'd0);

   ldpc_feed_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (srst),
      .push  (s_valid && s_ready),
      .wdata ({s_sof, s_modcod, s_data}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      pop = 1'b0;
      if (!fifo_empty) begin
         case (state)
            IDLE:    pop = !head_sof || !head_mc_ok;
            DROP:    pop = !head_sof;
            DATA:    pop = !pad && (!head_sof || first);
            default: pop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state         <= IDLE;
         count         <= '0;
         mc_l          <= '0;
         first         <= 1'b0;
         pad           <= 1'b0;
         enc_sof       <= 1'b0;
         enc_modcod    <= '0;
         enc_din       <= '0;
         enc_din_valid <= 1'b0;
         err_short     <= 1'b0;
         err_long      <= 1'b0;
         err_modcod    <= 1'b0;
      end else begin
         enc_sof       <= 1'b0;
         enc_din_valid <= 1'b0;
         err_short     <= 1'b0;
         err_long      <= 1'b0;
         err_modcod    <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (!head_sof) begin
                     err_long <= 1'b1;
                  end else if (head_mc_ok) begin
                     mc_l  <= head_mc;
                     count <= head_k >> SHIFT;
                     state <= WAIT_RDY;
                  end else begin
                     err_modcod <= 1'b1;
                     state      <= DROP;
                  end
               end
            end
            DROP: begin
               if (!fifo_empty && head_sof)
                  state <= IDLE;
            end
            WAIT_RDY: begin
               if (enc_rdy) begin
                  enc_sof    <= 1'b1;
                  enc_modcod <= mc_l;
                  first      <= 1'b1;
                  pad        <= 1'b0;
                  state      <= SOF;
               end
            end
            SOF: state <= DATA;
            DATA: begin
               if (pad) begin
                  enc_din       <= '0;
                  enc_din_valid <= 1'b1;
                  count         <= count - 16'd1;
                  if (count == 16'd1)
                     state <= IDLE;
               end else if (!fifo_empty) begin
                  if (!head_sof || first) begin
                     enc_din       <= head_data;
                     enc_din_valid <= 1'b1;
                     first         <= 1'b0;
                     count         <= count - 16'd1;
                     if (count == 16'd1)
                        state <= IDLE;
                  end else begin
                     // next frame arrived early: leave its sof in the FIFO and zero-fill
                     err_short <= 1'b1;
                     pad       <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LDPC_FEED_ERR_CNT_EN
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         cnt_short  <= '0;
         cnt_long   <= '0;
         cnt_modcod <= '0;
      end else begin
         if (err_short && cnt_short != 16'hFFFF)
            cnt_short <= cnt_short + 16'd1;
         if (err_long && cnt_long != 16'hFFFF)
            cnt_long <= cnt_long + 16'd1;
         if (err_modcod && cnt_modcod != 16'hFFFF)
            cnt_modcod <= cnt_modcod + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/ldpc_enc_frame_feeder.md
# ldpc_enc_frame_feeder

Upstream feeder for `ldpc_enc_64800`: accepts BCH-encoded information words on a valid/ready stream, buffers them, waits for the encoder's `rdy`, then issues the one-cycle `in_sof` + `in_modcod` start and streams exactly Kldpc/DW words on `din`/`din_valid`. It enforces frame length per MODCOD: short frames are zero-padded, surplus words are dropped, and invalid MODCODs are discarded, so the encoder never sees a malformed frame.

## Interface
- `DW`, 8, data word width; must be 1, 2, 4 or 8, so it divides every Kldpc.
- `FIFO_DEPTH`, 16, input buffer entries; power of 2, ≥ 4.
- `clk`  in  1  clock.
- `srst`  in  1  reset; asynchronous, active-high.
- `s_data`  in  DW  input word.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input accept; `s_valid && s_ready` is a beat.
- `s_sof`  in  1  beat is the first word of a frame.
- `s_modcod`  in  5  DVB-S2 MODCOD, sampled on sof beats only.
- `enc_rdy`  in  1  encoder ready for a new frame.
- `enc_sof`  out  1  one-cycle frame start to encoder `in_sof`.
- `enc_modcod`  out  5  to encoder `in_modcod`.
- `enc_din`  out  DW  to encoder `din`.
- `enc_din_valid`  out  1  to encoder `din_valid`.
- `err_short`  out  1  one-cycle pulse: frame padded.
- `err_long`  out  1  one-cycle pulse per discarded stray word.
- `err_modcod`  out  1  one-cycle pulse: frame dropped for invalid MODCOD.

## Operation
- FIFO entries are {sof, modcod, data}. `s_ready` = FIFO not full.
- Kldpc by code rate: 1/4 16200, 1/3 21600, 2/5 25920, 1/2 32400, 3/5 38880, 2/3 43200, 3/4 48600, 4/5 51840, 5/6 54000, 8/9 57600, 9/10 58320.
- MODCOD map: 1–3 QPSK 1/4, 1/3, 2/5; 4–11 QPSK 1/2, 3/5, 2/3, 3/4, 4/5, 5/6, 8/9, 9/10; 12–17 8PSK 3/5, 2/3, 3/4, 5/6, 8/9, 9/10; 18–23 16APSK 2/3, 3/4, 4/5, 5/6, 8/9, 9/10; 24–28 32APSK 3/4, 4/5, 5/6, 8/9, 9/10.
- MODCOD 0 and 29–31 are invalid.
- Word counter is 16 bits and loads Kldpc/DW.
- FSM:
  - IDLE: FIFO head non-sof → pop, pulse `err_long`. Head sof with valid MODCOD → latch MODCOD and count, go to WAIT_RDY. Head sof with invalid MODCOD → pop, pulse `err_modcod`, go to DROP.
  - DROP: pop non-sof heads silently; a sof head goes to IDLE without popping.
  - WAIT_RDY: `enc_rdy`=1 → SOF.
  - SOF: `enc_sof`=1 for exactly one cycle; `enc_modcod` updates this cycle and holds until the next SOF; go to DATA.
  - DATA: the head is popped and emitted with `enc_din_valid`=1 when it is the frame's own sof entry (first word) or a non-sof entry. FIFO empty → bubble: `enc_din_valid`=0, no count. A sof head after the first word means a premature frame end: pulse `err_short` once, then emit `enc_din`=0 with valid every cycle without popping until the count is exhausted. Last word → IDLE.
- The encoder tolerates bubbles in `din_valid`; the feeder never inserts words beyond Kldpc/DW.

## Timing
- Reset values: all outputs 0 except `s_ready`=1; FSM in IDLE; FIFO empty; counters 0.
- Reset mid-frame: immediate abort. No pad is issued; the encoder is reset by its own `srst`.
- FIFO write at edge t → head visible at t+1.
- IDLE→WAIT_RDY takes 1 cycle.
- `enc_rdy` sampled high at edge n → `enc_sof` high in cycle n+1 → first `enc_din_valid` no earlier than n+2.
- Data path to encoder is registered: `enc_din`/`enc_din_valid` are flops.
- Pad words are emitted back-to-back, one per cycle.
- Simultaneous FIFO push and pop when full is allowed; `s_ready` derives from the registered full flag.

## Configuration
- `LDPC_FEED_ERR_CNT_EN` defined: adds outputs `cnt_short`, `cnt_long`, `cnt_modcod` (16 bits each). Each is a saturating counter incremented on its error pulse, cleared by reset.
- `LDPC_FEED_ERR_CNT_EN` undefined: these ports and counters are absent. Error pulses are unchanged.

## Structure
- Package `ldpc_enc_pkg`:
  - MODCOD width constant (5).
  - Function `kldpc_of(modcod)` returning Kldpc, or 0 for invalid.
  - FSM state enum {IDLE, DROP, WAIT_RDY, SOF, DATA}.
- Sub-module `ldpc_feed_fifo`: single-clock FIFO, width DW+6, depth FIFO_DEPTH, first-word-fall-through head, full/empty flags.

## Test plan
- Nominal frame: MODCOD 1, DW=8, 2025 contiguous words, `enc_rdy` held high. Expect one `enc_sof` with `enc_modcod`=1, exactly 2025 `enc_din_valid` beats in order, no error pulses.
- `enc_rdy` low 100 cycles after sof arrives: no `enc_sof` while low. `s_ready` falls after 16 buffered words. Sof follows 1 cycle after `enc_rdy` rises; data is lossless.
- Short frame: MODCOD 4 (4050 words) followed by a new sof after 10 words. Expect 10 real words, one `err_short` pulse, 4040 zero words, then the second frame starts normally.
- Long frame: MODCOD 11 (7290 words) with 7293 words sent. Expect 7290 words to the encoder and 3 `err_long` pulses.
- MODCOD 0 frame, then a valid MODCOD 12 frame: one `err_modcod` pulse, no `enc_sof` for the first frame, second frame delivered intact.
- Async reset asserted mid-DATA: all outputs go to reset values without waiting for a clock edge. After release, the next frame completes normally.
